// File: rtl/fb_port_arbiter.sv
// Framebuffer port-A owner: round-robin arbiter for two requesters plus a
// clear-screen fill engine. RAM port-A controls are registered; read data
// comes back two cycles after the ack and is steered by an owner tag pipe.
module fb_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 12,
  parameter int FB_WORDS = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] addr_a,
  output logic [DATA_W-1:0] data_in_a,
  output logic              wr_en,
  output logic              rd_en,
  input  logic [DATA_W-1:0] data_out_a
);

  // One extra bit so a full 2^ADDR_W fill reaches its end count without wrap.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FB_END = CNT_W'(FB_WORDS);

  typedef enum logic {S_ARB = 1'b0, S_FILL = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              last_gnt;   // 1 = requester 1 was granted last
  logic [CNT_W-1:0]  fill_cnt;   // next fill address to issue
  logic [DATA_W-1:0] fill_col;
  logic              fill_go, fill_end;

  logic              any_ack, sel_we, in_rng;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rd_data;

  // Read tag pipe: stage 1 = port cycle, stage 2 = data return cycle.
  logic [2:1] vld_pipe, own_pipe, oob_pipe;

  assign fill_go  = (state == S_ARB) && fill_start;
  assign fill_end = (state == S_FILL) && (fill_cnt == FB_END);

  assign any_ack   = r0_ack | r1_ack;
  assign sel_we    = r1_ack ? r1_we    : r0_we;
  assign sel_addr  = r1_ack ? r1_addr  : r0_addr;
  assign sel_wdata = r1_ack ? r1_wdata : r0_wdata;
  assign in_rng    = {1'b0, sel_addr} < FB_END;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_ARB;
    else       state <= state_nxt;
  end

  // Next-state: fill_start wins over requests, fill ends after last write
  always_comb begin
    state_nxt = state;
    case (state)
      S_ARB:  if (fill_start)          state_nxt = S_FILL;
      S_FILL: if (fill_cnt == FB_END)  state_nxt = S_ARB;
    endcase
  end

  // Outputs: combinational acks with round-robin tie break, busy flag
  always_comb begin
    r0_ack    = 1'b0;
    r1_ack    = 1'b0;
    fill_busy = 1'b0;
    case (state)
      S_ARB: if (!fill_start) begin
        r0_ack = r0_req && (!r1_req ||  last_gnt);
        r1_ack = r1_req && (!r0_req || !last_gnt);
      end
      S_FILL: fill_busy = 1'b1;
    endcase
  end

  // Port-A drive: fill writes or the granted transaction, one per cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_a    <= '0;
      data_in_a <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      fill_cnt  <= '0;
      fill_col  <= '0;
      fill_done <= 1'b0;
      last_gnt  <= 1'b1;
    end else begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      fill_done <= 1'b0;
      if (fill_go) begin
        // First fill write goes out with the state change.
        fill_col  <= fill_color;
        addr_a    <= '0;
        data_in_a <= fill_color;
        wr_en     <= 1'b1;
        fill_cnt  <= CNT_W'(1);
      end else if (state == S_FILL) begin
        if (fill_end) begin
          fill_done <= 1'b1;
        end else begin
          addr_a    <= fill_cnt[ADDR_W-1:0];
          data_in_a <= fill_col;
          wr_en     <= 1'b1;
          fill_cnt  <= fill_cnt + CNT_W'(1);
        end
      end else if (any_ack) begin
        // Out-of-range accesses are acked but never reach the RAM.
        last_gnt  <= r1_ack;
        addr_a    <= sel_addr;
        data_in_a <= sel_wdata;
        wr_en     <= sel_we && in_rng;
        rd_en     <= !sel_we && in_rng;
      end
    end
  end

  // Owner/out-of-range tag pipe for read returns; runs through fills
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_pipe <= '0;
      own_pipe <= '0;
      oob_pipe <= '0;
    end else begin
      vld_pipe[1] <= any_ack && !sel_we;
      own_pipe[1] <= r1_ack;
      oob_pipe[1] <= !in_rng;
      vld_pipe[2] <= vld_pipe[1];
      own_pipe[2] <= own_pipe[1];
      oob_pipe[2] <= oob_pipe[1];
    end
  end

  assign rd_data   = oob_pipe[2] ? '0 : data_out_a;
  assign r0_rvalid = vld_pipe[2] && !own_pipe[2];
  assign r1_rvalid = vld_pipe[2] &&  own_pipe[2];
  assign r0_rdata  = r0_rvalid ? rd_data : '0;
  assign r1_rdata  = r1_rvalid ? rd_data : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: a full-size instance for arbitration/read
// tables and a 16-word instance for fill, reset-abort and out-of-range cases.
// Both share stimulus; each has its own behavioural port-A RAM.
module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we, fill_start;
  logic [11:0] r0_addr, r0_wdata, r1_addr, r1_wdata, fill_color;

  logic        r0_ack_b, r1_ack_b, r0_rvalid_b, r1_rvalid_b, fill_busy_b, fill_done_b, wr_en_b, rd_en_b;
  logic [11:0] r0_rdata_b, r1_rdata_b, addr_a_b, data_in_a_b, dout_b;
  logic        r0_ack_s, r1_ack_s, r0_rvalid_s, r1_rvalid_s, fill_busy_s, fill_done_s, wr_en_s, rd_en_s;
  logic [11:0] r0_rdata_s, r1_rdata_s, addr_a_s, data_in_a_s, dout_s;

  logic [11:0] mem_b [4096];
  logic [11:0] mem_s [4096];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fb_port_arbiter #(.ADDR_W(12), .DATA_W(12), .FB_WORDS(4096)) u_big (
    .i_clk(clk), .i_rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack_b), .r0_rvalid(r0_rvalid_b), .r0_rdata(r0_rdata_b),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack_b), .r1_rvalid(r1_rvalid_b), .r1_rdata(r1_rdata_b),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy_b), .fill_done(fill_done_b),
    .addr_a(addr_a_b), .data_in_a(data_in_a_b), .wr_en(wr_en_b), .rd_en(rd_en_b),
    .data_out_a(dout_b)
  );

  fb_port_arbiter #(.ADDR_W(12), .DATA_W(12), .FB_WORDS(16)) u_small (
    .i_clk(clk), .i_rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack_s), .r0_rvalid(r0_rvalid_s), .r0_rdata(r0_rdata_s),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack_s), .r1_rvalid(r1_rvalid_s), .r1_rdata(r1_rdata_s),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy_s), .fill_done(fill_done_s),
    .addr_a(addr_a_s), .data_in_a(data_in_a_s), .wr_en(wr_en_s), .rd_en(rd_en_s),
    .data_out_a(dout_s)
  );

  // Synchronous single-port RAM models; read data holds when rd_en is low
  always @(posedge clk) begin
    if (wr_en_b) mem_b[addr_a_b] <= data_in_a_b;
    if (rd_en_b) dout_b <= mem_b[addr_a_b];
    if (wr_en_s) mem_s[addr_a_s] <= data_in_a_s;
    if (rd_en_s) dout_s <= mem_s[addr_a_s];
  end

  typedef struct {
    logic q0, w0; logic [11:0] a0, d0;
    logic q1, w1; logic [11:0] a1, d1;
    logic [1:0] e_ack; logic e_wr, e_rd; logic [11:0] e_addr, e_din;
    logic [1:0] e_rv; logic [11:0] e_rdat;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t row(
    input logic q0, input logic w0, input logic [11:0] a0, input logic [11:0] d0,
    input logic q1, input logic w1, input logic [11:0] a1, input logic [11:0] d1,
    input logic [1:0] ack, input logic wr, input logic rd,
    input logic [11:0] ad, input logic [11:0] di,
    input logic [1:0] rv, input logic [11:0] rdat);
    vec_t v;
    v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.e_ack = ack; v.e_wr = wr; v.e_rd = rd; v.e_addr = ad; v.e_din = di;
    v.e_rv = rv; v.e_rdat = rdat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    fill_start = 0;
  endtask

  logic [1:0]  ack_a, rv_a;
  logic [11:0] rdat_a;
  bit          ok;
  int          bad_words, saw;

  initial begin
    // r0 fields | r1 fields | ack{r1,r0} wr rd addr din | rvalid{r1,r0} rdata
    tbl[0]  = row(1,1,12'h010,12'h0A5, 0,0,12'h000,12'h000, 2'b01,0,0,12'h000,12'h000, 2'b00,12'h000);
    tbl[1]  = row(1,0,12'h010,12'h000, 0,0,12'h000,12'h000, 2'b01,1,0,12'h010,12'h0A5, 2'b00,12'h000);
    tbl[2]  = row(0,0,12'h000,12'h000, 0,0,12'h000,12'h000, 2'b00,0,1,12'h010,12'h000, 2'b00,12'h000);
    tbl[3]  = row(0,0,12'h000,12'h000, 0,0,12'h000,12'h000, 2'b00,0,0,12'h000,12'h000, 2'b01,12'h0A5);
    tbl[4]  = row(0,0,12'h000,12'h000, 1,1,12'h020,12'h111, 2'b10,0,0,12'h000,12'h000, 2'b00,12'h000);
    tbl[5]  = row(1,1,12'h021,12'h222, 1,1,12'h030,12'h333, 2'b01,1,0,12'h020,12'h111, 2'b00,12'h000);
    tbl[6]  = row(1,1,12'h022,12'h444, 1,1,12'h030,12'h333, 2'b10,1,0,12'h021,12'h222, 2'b00,12'h000);
    tbl[7]  = row(1,1,12'h022,12'h444, 1,1,12'h031,12'h555, 2'b01,1,0,12'h030,12'h333, 2'b00,12'h000);
    tbl[8]  = row(1,1,12'h023,12'h666, 1,1,12'h031,12'h555, 2'b10,1,0,12'h022,12'h444, 2'b00,12'h000);
    tbl[9]  = row(1,1,12'h023,12'h666, 0,0,12'h000,12'h000, 2'b01,1,0,12'h031,12'h555, 2'b00,12'h000);
    tbl[10] = row(0,0,12'h000,12'h000, 0,0,12'h000,12'h000, 2'b00,1,0,12'h023,12'h666, 2'b00,12'h000);
    tbl[11] = row(0,0,12'h000,12'h000, 1,0,12'h020,12'h000, 2'b10,0,0,12'h000,12'h000, 2'b00,12'h000);
    tbl[12] = row(1,0,12'h021,12'h000, 0,0,12'h000,12'h000, 2'b01,0,1,12'h020,12'h000, 2'b00,12'h000);
    tbl[13] = row(0,0,12'h000,12'h000, 0,0,12'h000,12'h000, 2'b00,0,1,12'h021,12'h000, 2'b10,12'h111);
    tbl[14] = row(0,0,12'h000,12'h000, 0,0,12'h000,12'h000, 2'b00,0,0,12'h000,12'h000, 2'b01,12'h222);
    tbl[15] = row(0,0,12'h000,12'h000, 1,0,12'h031,12'h000, 2'b10,0,0,12'h000,12'h000, 2'b00,12'h000);
    tbl[16] = row(0,0,12'h000,12'h000, 0,0,12'h000,12'h000, 2'b00,0,1,12'h031,12'h000, 2'b00,12'h000);
    tbl[17] = row(0,0,12'h000,12'h000, 0,0,12'h000,12'h000, 2'b00,0,0,12'h000,12'h000, 2'b10,12'h555);

    rst = 1; fill_color = '0; idle_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_big", {r0_ack_b, r1_ack_b, r0_rvalid_b, r1_rvalid_b, fill_busy_b, fill_done_b,
                      wr_en_b, rd_en_b, addr_a_b, data_in_a_b}, 32'h0);
    chk("reset_small", {r0_ack_s, r1_ack_s, r0_rvalid_s, r1_rvalid_s, fill_busy_s, fill_done_s,
                        wr_en_s, rd_en_s, addr_a_s, data_in_a_s}, 32'h0);

    // Arbitration / read-latency table on the full-size instance
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      rst = 0;
      r0_req = tbl[i].q0; r0_we = tbl[i].w0; r0_addr = tbl[i].a0; r0_wdata = tbl[i].d0;
      r1_req = tbl[i].q1; r1_we = tbl[i].w1; r1_addr = tbl[i].a1; r1_wdata = tbl[i].d1;
      @(negedge clk);
      ack_a  = {r1_ack_b, r0_ack_b};
      rv_a   = {r1_rvalid_b, r0_rvalid_b};
      rdat_a = r1_rvalid_b ? r1_rdata_b : r0_rdata_b;
      ok = (ack_a == tbl[i].e_ack) && (wr_en_b == tbl[i].e_wr) && (rd_en_b == tbl[i].e_rd) &&
           (!(tbl[i].e_wr || tbl[i].e_rd) || addr_a_b == tbl[i].e_addr) &&
           (!tbl[i].e_wr || data_in_a_b == tbl[i].e_din) &&
           (rv_a == tbl[i].e_rv) && (tbl[i].e_rv == 2'b00 || rdat_a == tbl[i].e_rdat);
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL row%0d: ack=%b wr=%b rd=%b addr=%h din=%h rv=%b rdata=%h, want ack=%b wr=%b rd=%b addr=%h din=%h rv=%b rdata=%h",
                 i, ack_a, wr_en_b, rd_en_b, addr_a_b, data_in_a_b, rv_a, rdat_a,
                 tbl[i].e_ack, tbl[i].e_wr, tbl[i].e_rd, tbl[i].e_addr, tbl[i].e_din, tbl[i].e_rv, tbl[i].e_rdat);
      end
    end

    // Fill on the 16-word instance while r0 holds a read of address 5
    @(posedge clk); #1;
    idle_in();
    fill_start = 1; fill_color = 12'hF00;
    r0_req = 1; r0_we = 0; r0_addr = 12'h005;
    @(negedge clk);
    chk("fill_start_no_ack", {r0_ack_s, r1_ack_s, fill_busy_s, wr_en_s}, 32'h0);
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      fill_start = (k == 4);       // restart attempt mid-fill must be ignored
      if (k == 4) fill_color = 12'h00F;
      @(negedge clk);
      chk($sformatf("fill_wr%0d", k),
          {r0_ack_s, fill_busy_s, fill_done_s, wr_en_s, rd_en_s, addr_a_s, data_in_a_s},
          {3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'(k), 12'hF00});
    end
    @(posedge clk); #1;
    fill_start = 0;
    @(negedge clk);
    chk("fill_done_cycle", {fill_busy_s, fill_done_s, r0_ack_s, wr_en_s}, 32'b0110);
    @(posedge clk); #1;
    r0_req = 0;
    @(negedge clk);
    chk("fill_after_rd", {fill_done_s, fill_busy_s, rd_en_s, addr_a_s}, {1'b0, 1'b0, 1'b1, 12'h005});
    @(posedge clk); #1;
    @(negedge clk);
    chk("fill_readback", {r0_rvalid_s, r1_rvalid_s, r0_rdata_s}, {1'b1, 1'b0, 12'hF00});
    bad_words = 0;
    for (int a = 0; a < 16; a++) if (mem_s[a] !== 12'hF00) bad_words++;
    chk("fill_mem_words_wrong", bad_words, 0);

    // Reset lands during the fifth fill write (address 4)
    @(posedge clk); #1;
    fill_start = 1; fill_color = 12'h0F0;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      fill_start = 0;
      if (k == 4) rst = 1;
      @(negedge clk);
      chk($sformatf("abort_wr%0d", k), {wr_en_s, addr_a_s, data_in_a_s}, {1'b1, 12'(k), 12'h0F0});
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("abort_state", {fill_busy_s, fill_done_s, wr_en_s}, 32'h0);
    saw = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fill_done_s || fill_busy_s || wr_en_s) saw++;
    end
    chk("abort_no_done", saw, 0);
    bad_words = 0;
    for (int a = 0; a < 16; a++)
      if (mem_s[a] !== ((a < 5) ? 12'h0F0 : 12'hF00)) bad_words++;
    chk("abort_mem_words_wrong", bad_words, 0);

    // Reset between ack and data return discards the read
    @(posedge clk); #1;
    r0_req = 1; r0_we = 0; r0_addr = 12'h001;
    @(negedge clk);
    chk("discard_ack", r0_ack_s, 1);
    @(posedge clk); #1;
    r0_req = 0; rst = 1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("discard_rvalid", {r0_rvalid_s, r1_rvalid_s}, 32'h0);

    // Out-of-range write then read on the 16-word instance
    @(posedge clk); #1;
    r0_req = 1; r0_we = 1; r0_addr = 12'h020; r0_wdata = 12'h123;
    @(negedge clk);
    chk("oor_wr_ack", r0_ack_s, 1);
    @(posedge clk); #1;
    r0_we = 0;
    @(negedge clk);
    chk("oor_rd_ack_no_wr", {r0_ack_s, wr_en_s, rd_en_s}, 32'b100);
    @(posedge clk); #1;
    r0_req = 0;
    @(negedge clk);
    chk("oor_no_port", {wr_en_s, rd_en_s, r0_rvalid_s}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("oor_rd_zero", {r0_rvalid_s, r1_rvalid_s, r0_rdata_s}, {1'b1, 1'b0, 12'h000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
